mb_pack: RTL and testbench

MB_PACK -- requirements
Module: mb_pack

---
 rtl/mb_pkg.sv | 17 +
 rtl/mb_pack.sv | 111 +++++++++++
 tb/tb_mb_pack.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mb_pkg.sv
// mb_pkg: constants and state encoding shared by the macroblock packer
// (mb_pack) and the macroblock serializer (mb_ser).
//   MB_COEFS : coefficients per macroblock
//   COEF_W   : signed quantized coefficient width
//   POS_W    : zigzag index width
//   SIZE_W   : entry count width (must hold MB_COEFS itself)
package mb_pkg;
  localparam int MB_COEFS = 64;
  localparam int COEF_W   = 12;
  localparam int POS_W    = 6;
  localparam int SIZE_W   = 7;

  typedef enum logic {
    ACC  = 1'b0,
    EMIT = 1'b1
  } mb_state_e;
endpackage

// File: rtl/mb_pack.sv
// mb_pack: packs the non-zero coefficients of one 64-coefficient macroblock
// (zigzag order) into a list of {sign, zigzag position} entries, then presents
// the list to a downstream macroblock FIFO with a single write strobe.
//
// Ports
//   clk            : system clock, rising edge
//   rst            : asynchronous reset, active low
//   clk_en         : global clock enable; low freezes all state, mb_wr low
//   coef_in        : signed coefficient, index 0 first
//   coef_valid     : coef_in valid
//   coef_slice_end : slice-end flag, sampled only on the index-63 beat
//   coef_ready     : high while accumulating
//   sign_out       : per-entry sign (1 = negative)
//   pos_out        : per-entry zigzag index
//   size_out       : number of valid entries, 0..64
//   slice_end_out  : this macroblock closes a slice
//   mb_wr          : write strobe into the downstream FIFO
//   mb_afull       : downstream FIFO almost full
module mb_pack
  import mb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic signed [COEF_W-1:0]  coef_in,
  input  logic                      coef_valid,
  input  logic                      coef_slice_end,
  output logic                      coef_ready,
  output logic [0:MB_COEFS-1]       sign_out,
  output logic [0:MB_COEFS-1][POS_W-1:0] pos_out,
  output logic [SIZE_W-1:0]         size_out,
  output logic                      slice_end_out,
  output logic                      mb_wr,
  input  logic                      mb_afull
);

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(MB_COEFS - 1);

  mb_state_e                        state_q,     state_d;
  logic [POS_W-1:0]                 index_q,     index_d;
  logic [SIZE_W-1:0]                size_q,      size_d;
  logic [0:MB_COEFS-1]              sign_q,      sign_d;
  logic [0:MB_COEFS-1][POS_W-1:0]   pos_q,       pos_d;
  logic                             slice_end_q, slice_end_d;

  logic accept;

  assign coef_ready    = (state_q == ACC);
  assign accept        = coef_valid && coef_ready && clk_en;
  // Combinational so the write lands in the first cycle the FIFO has room.
  assign mb_wr         = (state_q == EMIT) && !mb_afull && clk_en;

  assign sign_out      = sign_q;
  assign pos_out       = pos_q;
  assign size_out      = size_q;
  assign slice_end_out = slice_end_q;

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    size_d      = size_q;
    sign_d      = sign_q;
    pos_d       = pos_q;
    slice_end_d = slice_end_q;

    if (accept) begin
      index_d = index_q + 1'b1;
      // size never exceeds 63 while a beat is being accepted, so the low
      // bits address the next free entry.
      if (coef_in != '0) begin
        sign_d[size_q[POS_W-1:0]] = coef_in[COEF_W-1];
        pos_d[size_q[POS_W-1:0]]  = index_q;
        size_d                    = size_q + 1'b1;
      end
      if (index_q == LAST_IDX) begin
        slice_end_d = coef_slice_end;
        state_d     = EMIT;
      end
    end

    // Clearing everything on the write edge keeps unused entries at zero
    // for the next macroblock without a separate clear pass.
    if (mb_wr) begin
      state_d     = ACC;
      index_d     = '0;
      size_d      = '0;
      sign_d      = '0;
      pos_d       = '0;
      slice_end_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACC;
      index_q     <= '0;
      size_q      <= '0;
      sign_q      <= '0;
      pos_q       <= '0;
      slice_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      size_q      <= size_d;
      sign_q      <= sign_d;
      pos_q       <= pos_d;
      slice_end_q <= slice_end_d;
    end
  end

endmodule

// File: tb/tb_mb_pack.sv
module tb_mb_pack;
  import mb_pkg::*;

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          clk_en;
  logic signed [COEF_W-1:0]      coef_in;
  logic                          coef_valid;
  logic                          coef_slice_end;
  logic                          coef_ready;
  logic [0:MB_COEFS-1]           sign_out;
  logic [0:MB_COEFS-1][POS_W-1:0] pos_out;
  logic [SIZE_W-1:0]             size_out;
  logic                          slice_end_out;
  logic                          mb_wr;
  logic                          mb_afull;

  mb_pack dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .coef_in        (coef_in),
    .coef_valid     (coef_valid),
    .coef_slice_end (coef_slice_end),
    .coef_ready     (coef_ready),
    .sign_out       (sign_out),
    .pos_out        (pos_out),
    .size_out       (size_out),
    .slice_end_out  (slice_end_out),
    .mb_wr          (mb_wr),
    .mb_afull       (mb_afull)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Current block stimulus and the reference result derived from it.
  logic [COEF_W-1:0]              blk [MB_COEFS];
  bit                             blk_slice;
  logic [0:MB_COEFS-1]            e_sign;
  logic [0:MB_COEFS-1][POS_W-1:0] e_pos;
  int                             e_size;
  bit                             e_slice;
  bit                             acc_wr_seen;

  typedef struct {
    int mode;       // 0 zeros, 1 i+1, 2 -1 at even, 3 only [63]=-5, 4 extremes
    bit slice;
    int afull_cyc;
    int en_cyc;
    int exp_size;
    bit exp_slice;
  } vec_t;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: list the non-zero coefficients in index order.
  task automatic model();
    e_sign = '0;
    e_pos  = '0;
    e_size = 0;
    for (int i = 0; i < MB_COEFS; i++) begin
      if (blk[i] != 0) begin
        e_sign[e_size] = blk[i][COEF_W-1];
        e_pos[e_size]  = POS_W'(i);
        e_size++;
      end
    end
    e_slice = blk_slice;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_size"},  size_out,      e_size);
    chk({tag, "_sign"},  sign_out,      e_sign);
    chk({tag, "_pos"},   pos_out,       e_pos);
    chk({tag, "_slice"}, slice_end_out, e_slice);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_size0"},  size_out,      0);
    chk({tag, "_sign0"},  sign_out,      0);
    chk({tag, "_pos0"},   pos_out,       0);
    chk({tag, "_slice0"}, slice_end_out, 0);
    chk({tag, "_ready1"}, coef_ready,    1);
    chk({tag, "_wr0"},    mb_wr,         0);
  endtask

  task automatic drive_beats(input int n, input bit stalls);
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      if (mb_wr) acc_wr_seen = 1'b1;
      // Frozen cycles: junk on the bus must not be taken while clk_en is low.
      while (stalls && $urandom_range(0, 3) == 0) begin
        clk_en         = 1'b0;
        coef_valid     = 1'($urandom);
        coef_in        = 12'($urandom);
        coef_slice_end = 1'($urandom);
        @(negedge clk);
      end
      clk_en = 1'b1;
      while (!coef_ready && guard < 50) begin
        guard++;
        @(negedge clk);
      end
      if (guard >= 50) chk("ready_timeout", coef_ready, 1);
      if (mb_wr) acc_wr_seen = 1'b1;
      coef_valid     = 1'b1;
      coef_in        = blk[i];
      coef_slice_end = (i == MB_COEFS - 1) ? blk_slice : 1'($urandom);
    end
    @(negedge clk);
    coef_valid     = 1'b0;
    coef_slice_end = 1'b0;
  endtask

  task automatic run_block(input int afull_cyc, input int en_cyc, input int t_size, input bit t_slice);
    model();
    acc_wr_seen = 1'b0;
    mb_afull    = (afull_cyc > 0);
    drive_beats(MB_COEFS, 1'b1);
    chk("no_wr_during_acc", acc_wr_seen, 0);
    chk("ready_low_emit", coef_ready, 0);
    for (int c = 0; c < afull_cyc; c++) begin
      chk("afull_wr_low", mb_wr, 0);
      chk("afull_ready_low", coef_ready, 0);
      check_outputs("afull_hold");
      @(negedge clk);
    end
    mb_afull = 1'b0;
    for (int c = 0; c < en_cyc; c++) begin
      clk_en = 1'b0;
      #1;
      chk("clken_wr_low", mb_wr, 0);
      check_outputs("clken_hold");
      @(negedge clk);
    end
    clk_en = 1'b1;
    #1;
    chk("mb_wr_pulse", mb_wr, 1);
    check_outputs("emit");
    if (t_size >= 0) begin
      chk("table_size", size_out, t_size);
      chk("table_slice", slice_end_out, t_slice);
    end
    @(negedge clk);
    check_cleared("after_wr");
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 1'b0, 0,  0, 0,  1'b0};
    vecs[1] = '{1, 1'b0, 0,  1, 64, 1'b0};
    vecs[2] = '{2, 1'b0, 0,  0, 32, 1'b0};
    vecs[3] = '{3, 1'b1, 0,  0, 1,  1'b1};
    vecs[4] = '{1, 1'b1, 10, 0, 64, 1'b1};
    vecs[5] = '{4, 1'b0, 2,  2, 64, 1'b0};

    rst            = 1'b1;
    clk_en         = 1'b1;
    coef_valid     = 1'b0;
    coef_in        = '0;
    coef_slice_end = 1'b0;
    mb_afull       = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_cleared("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed table
    foreach (vecs[v]) begin
      for (int i = 0; i < MB_COEFS; i++) begin
        case (vecs[v].mode)
          0: blk[i] = 12'd0;
          1: blk[i] = 12'(i + 1);
          2: blk[i] = (i % 2 == 0) ? 12'hFFF : 12'd0;
          3: blk[i] = (i == MB_COEFS - 1) ? 12'hFFB : 12'd0;
          default: blk[i] = (i % 2 == 0) ? 12'h800 : 12'h7FF;
        endcase
      end
      blk_slice = vecs[v].slice;
      run_block(vecs[v].afull_cyc, vecs[v].en_cyc, vecs[v].exp_size, vecs[v].exp_slice);
    end

    // Randomized blocks
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < MB_COEFS; i++)
        blk[i] = ($urandom_range(0, 1) == 0) ? 12'd0 : 12'($urandom);
      blk_slice = 1'($urandom);
      run_block($urandom_range(0, 3), $urandom_range(0, 1), -1, 1'b0);
    end

    // Reset in the middle of a block
    for (int i = 0; i < MB_COEFS; i++) blk[i] = 12'(i + 7);
    blk_slice = 1'b1;
    drive_beats(20, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_cleared("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < MB_COEFS; i++)
      blk[i] = (i % 3 == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
    blk_slice = 1'b0;
    run_block(0, 0, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
